// File: rtl/huffman_merge_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : huffman_merge_ctrl_pkg
// Purpose  : Shared constants, the node-table entry layout and the
//            controller state encoding for the Huffman merge controller.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package huffman_merge_ctrl_pkg;

    localparam int N_LEAF       = 16;
    localparam int SENT_ID      = 31;  // node id carried by empty table slots
    localparam int FIRST_PARENT = 16;  // first internal-node id
    localparam int WSIZE_DEF    = 8;
    localparam int IDW_DEF      = 5;

    // Node-table entry: the weight sits above the id so that an unsigned
    // compare of the packed entry orders by weight and then by lower id.
    typedef struct packed {
        logic [WSIZE_DEF-1:0] w;
        logic [IDW_DEF-1:0]   id;
    } entry_t;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        LOAD = 3'd1,
        SORT = 3'd2,
        EMIT = 3'd3,
        DONE = 3'd4
    } state_t;

endpackage : huffman_merge_ctrl_pkg
`default_nettype wire

// File: rtl/huffman_merge_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : huffman_merge_ctrl_if
// Purpose  : Bundles the leaf-load stream, merge-record stream and build
//            control/status signals of the Huffman merge controller.
// Ports    : master modport - controller side (drives in_ready, m_*, status)
//            slave modport  - environment side (drives start, leaves, m_ready)
// Revision : 1.0 - initial release
// ============================================================================
interface huffman_merge_ctrl_if
    import huffman_merge_ctrl_pkg::*;
#(
    parameter int WSIZE = WSIZE_DEF,
    parameter int IDW   = IDW_DEF
);
    logic             start;
    logic             in_valid;
    logic             in_ready;
    logic [WSIZE-1:0] in_weight;
    logic             m_valid;
    logic             m_ready;
    logic [IDW-1:0]   m_left;
    logic [IDW-1:0]   m_right;
    logic [IDW-1:0]   m_parent;
    logic [WSIZE-1:0] m_weight;
    logic             busy;
    logic             done;
    logic [IDW-1:0]   root_id;
    logic             root_valid;

    modport master (
        input  start, in_valid, in_weight, m_ready,
        output in_ready, m_valid, m_left, m_right, m_parent, m_weight,
               busy, done, root_id, root_valid
    );

    modport slave (
        output start, in_valid, in_weight, m_ready,
        input  in_ready, m_valid, m_left, m_right, m_parent, m_weight,
               busy, done, root_id, root_valid
    );

endinterface : huffman_merge_ctrl_if
`default_nettype wire

// File: rtl/huffman_merge_ctrl_sortx16.sv
`default_nettype none
// ============================================================================
// Module   : SortX16
// Purpose  : Purely combinational 16-entry ascending sorter (odd-even
//            transposition network, 16 compare-exchange rounds).
// Ports    : d_i - 16 unsorted entries of DSIZE bits
//            q_o - the same entries, q_o[0] smallest
// Params   : DSIZE  - entry width
//            OFFSET - width of the low tag field; entries order by the
//                     upper key field first, then by the tag
// Revision : 1.0 - initial release
// ============================================================================
module SortX16 #(
    parameter int DSIZE  = 13,
    parameter int OFFSET = 5
) (
    input  logic [15:0][DSIZE-1:0] d_i,
    output logic [15:0][DSIZE-1:0] q_o
);

    logic [15:0][DSIZE-1:0] net;
    logic [DSIZE-1:0]       tmp;

    // True when a may stay in front of b.
    function automatic logic in_order(input logic [DSIZE-1:0] a,
                                      input logic [DSIZE-1:0] b);
        if (a[DSIZE-1:OFFSET] != b[DSIZE-1:OFFSET])
            return a[DSIZE-1:OFFSET] < b[DSIZE-1:OFFSET];
        return a[OFFSET-1:0] <= b[OFFSET-1:0];
    endfunction

    // Even rounds compare (0,1),(2,3)...; odd rounds (1,2),(3,4)...
    // Sixteen rounds fully sort sixteen entries.
    always_comb begin
        net = d_i;
        tmp = '0;
        for (int s = 0; s < 16; s++) begin
            for (int i = s % 2; i < 15; i += 2) begin
                if (!in_order(net[i], net[i+1])) begin
                    tmp      = net[i];
                    net[i]   = net[i+1];
                    net[i+1] = tmp;
                end
            end
        end
        q_o = net;
    end

endmodule : SortX16
`default_nettype wire

// File: rtl/huffman_merge_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : huffman_merge_ctrl
// Purpose  : Builds a Huffman tree from 16 leaf weights. Leaves are loaded
//            serially into a node table; each sort/merge step pairs the two
//            lightest live nodes, emits a merge record and writes the parent
//            back into the table.
// Ports    : clk, rst_n (async active-low)
//            bus.master - start, leaf stream (in_*), merge stream (m_*),
//                         busy, done pulse, root_id/root_valid result
// Revision : 1.0 - initial release
// ============================================================================
module huffman_merge_ctrl
    import huffman_merge_ctrl_pkg::*;
#(
    parameter int WSIZE = WSIZE_DEF,
    parameter int IDW   = IDW_DEF
) (
    input  logic                clk,
    input  logic                rst_n,
    huffman_merge_ctrl_if.master bus
);

    localparam int               KW       = WSIZE + IDW;
    localparam logic [WSIZE-1:0] MAX_W    = {{(WSIZE-1){1'b1}}, 1'b0};
    localparam logic [KW-1:0]    SENT_KEY = {{WSIZE{1'b1}}, IDW'(SENT_ID)};

    state_t                     state_q, state_d;
    logic [N_LEAF-1:0][KW-1:0]  table_q, table_d;
    logic [N_LEAF-1:0][KW-1:0]  snap_q, snap_d;
    logic [N_LEAF-1:0][KW-1:0]  sorted;
    logic [4:0]                 live_q, live_d;
    logic [IDW-1:0]             next_id_q, next_id_d;
    logic [3:0]                 idx_q, idx_d;
    logic [IDW-1:0]             root_id_q, root_id_d;
    logic                       root_valid_q, root_valid_d;

    logic [WSIZE-1:0]           load_w;
    logic [WSIZE:0]             sum_w;
    logic [WSIZE-1:0]           merge_w;
    logic                       emitting;

    SortX16 #(
        .DSIZE  (KW),
        .OFFSET (IDW)
    ) u_sort (
        .d_i (table_q),
        .q_o (sorted)
    );

    // The all-ones weight belongs to the sentinel, so real weights top out
    // one below it both on load and after a merge.
    assign load_w  = (bus.in_weight > MAX_W) ? MAX_W : bus.in_weight;
    assign sum_w   = {1'b0, snap_q[0][KW-1:IDW]} + {1'b0, snap_q[1][KW-1:IDW]};
    assign merge_w = (sum_w > {1'b0, MAX_W}) ? MAX_W : sum_w[WSIZE-1:0];

    // Merge outputs come straight from the snapshot, which only changes in
    // SORT, so they hold steady for as long as a record is stalled.
    assign emitting       = (state_q == EMIT);
    assign bus.in_ready   = (state_q == LOAD);
    assign bus.m_valid    = emitting;
    assign bus.m_left     = emitting ? snap_q[0][IDW-1:0] : '0;
    assign bus.m_right    = emitting ? snap_q[1][IDW-1:0] : '0;
    assign bus.m_parent   = emitting ? next_id_q : '0;
    assign bus.m_weight   = emitting ? merge_w : '0;
    assign bus.busy       = (state_q != IDLE);
    assign bus.done       = (state_q == DONE);
    assign bus.root_id    = root_id_q;
    assign bus.root_valid = root_valid_q;

    always_comb begin
        state_d      = state_q;
        table_d      = table_q;
        snap_d       = snap_q;
        live_d       = live_q;
        next_id_d    = next_id_q;
        idx_d        = idx_q;
        root_id_d    = root_id_q;
        root_valid_d = root_valid_q;

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    for (int i = 0; i < N_LEAF; i++) table_d[i] = SENT_KEY;
                    live_d       = '0;
                    next_id_d    = IDW'(FIRST_PARENT);
                    idx_d        = '0;
                    root_id_d    = '0;
                    root_valid_d = 1'b0;
                    state_d      = LOAD;
                end
            end
            LOAD: begin
                if (bus.in_valid) begin
                    // Absent symbols stay as sentinels and never take part.
                    if (bus.in_weight == '0) begin
                        table_d[idx_q] = SENT_KEY;
                    end else begin
                        table_d[idx_q] = {load_w, IDW'(idx_q)};
                        live_d         = live_q + 5'd1;
                    end
                    idx_d = idx_q + 4'd1;
                    if (idx_q == 4'd15) state_d = SORT;
                end
            end
            SORT: begin
                snap_d = sorted;
                if (live_q <= 5'd1) begin
                    root_valid_d = (live_q == 5'd1);
                    root_id_d    = (live_q == 5'd1) ? sorted[0][IDW-1:0] : '0;
                    state_d      = DONE;
                end else begin
                    state_d = EMIT;
                end
            end
            EMIT: begin
                if (bus.m_ready) begin
                    // Drop the two children, insert the parent; the vacated
                    // last slot becomes a sentinel.
                    table_d[0] = {merge_w, next_id_q};
                    for (int i = 1; i < N_LEAF - 1; i++) table_d[i] = snap_q[i+1];
                    table_d[N_LEAF-1] = SENT_KEY;
                    next_id_d = next_id_q + IDW'(1);
                    live_d    = live_q - 5'd1;
                    state_d   = SORT;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            table_q      <= {N_LEAF{SENT_KEY}};
            snap_q       <= {N_LEAF{SENT_KEY}};
            live_q       <= '0;
            next_id_q    <= IDW'(FIRST_PARENT);
            idx_q        <= '0;
            root_id_q    <= '0;
            root_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            table_q      <= table_d;
            snap_q       <= snap_d;
            live_q       <= live_d;
            next_id_q    <= next_id_d;
            idx_q        <= idx_d;
            root_id_q    <= root_id_d;
            root_valid_q <= root_valid_d;
        end
    end

endmodule : huffman_merge_ctrl
`default_nettype wire

// File: tb/tb_huffman_merge_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_huffman_merge_ctrl
// Purpose  : Directed self-checking bench for huffman_merge_ctrl.
// Ports    : none
// Revision : 1.0 - initial release
// ============================================================================
module tb_huffman_merge_ctrl;
    import huffman_merge_ctrl_pkg::*;

    localparam int WSIZE = 8;
    localparam int IDW   = 5;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    huffman_merge_ctrl_if #(.WSIZE(WSIZE), .IDW(IDW)) bus ();

    huffman_merge_ctrl #(.WSIZE(WSIZE), .IDW(IDW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_chk  = 0;
    int n_pass = 0;

    // Captured merge records and build result of the latest collect run.
    int         rec_n;
    logic [4:0] rec_l [16];
    logic [4:0] rec_r [16];
    logic [4:0] rec_p [16];
    logic [7:0] rec_w [16];
    logic       done_seen;
    logic [4:0] res_root;
    logic       res_rv;

    logic [7:0] W_MAIN [16] = '{8'd3, 8'd9, 8'd15, 8'd6, 8'd12, 8'd2, 8'd8, 8'd14,
                               8'd4, 8'd10, 8'd0, 8'd1, 8'd7, 8'd23, 8'd13, 8'd5};
    logic [7:0] w_vec [16];

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [7:0] w [16]);
        bus.start = 1'b1;
        tick();
        bus.start    = 1'b0;
        bus.in_valid = 1'b1;
        for (int i = 0; i < 16; i++) begin
            bus.in_weight = w[i];
            tick();
        end
        bus.in_valid  = 1'b0;
        bus.in_weight = '0;
    endtask

    task automatic collect(input int budget);
        rec_n     = 0;
        done_seen = 1'b0;
        for (int c = 0; c < budget && !done_seen; c++) begin
            if (bus.m_valid && bus.m_ready) begin
                if (rec_n < 16) begin
                    rec_l[rec_n] = bus.m_left;
                    rec_r[rec_n] = bus.m_right;
                    rec_p[rec_n] = bus.m_parent;
                    rec_w[rec_n] = bus.m_weight;
                end
                rec_n++;
            end
            if (bus.done) begin
                done_seen = 1'b1;
                res_root  = bus.root_id;
                res_rv    = bus.root_valid;
            end
            tick();
        end
        if (!done_seen) check("done_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_mvalid(input int budget);
        for (int c = 0; c < budget && !bus.m_valid; c++) tick();
        if (!bus.m_valid) check("mvalid_timeout", 32'd0, 32'd1);
    endtask

    task automatic check_main_run(input string tag);
        check({tag, "_nrec"},    rec_n,     14);
        check({tag, "_r0_l"},    rec_l[0],  11);
        check({tag, "_r0_r"},    rec_r[0],  5);
        check({tag, "_r0_p"},    rec_p[0],  16);
        check({tag, "_r0_w"},    rec_w[0],  3);
        check({tag, "_r1_l"},    rec_l[1],  0);
        check({tag, "_r1_r"},    rec_r[1],  16);
        check({tag, "_r1_p"},    rec_p[1],  17);
        check({tag, "_r1_w"},    rec_w[1],  6);
        check({tag, "_last_p"},  rec_p[13], 29);
        check({tag, "_last_w"},  rec_w[13], 132);
        check({tag, "_root"},    res_root,  29);
        check({tag, "_root_v"},  res_rv,    1);
    endtask

    initial begin
        bus.start     = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_weight = '0;
        bus.m_ready   = 1'b0;
        rst_n         = 1'b0;
        repeat (3) tick();

        // Reset state
        check("rst_m_valid",    bus.m_valid,    0);
        check("rst_busy",       bus.busy,       0);
        check("rst_done",       bus.done,       0);
        check("rst_in_ready",   bus.in_ready,   0);
        check("rst_root_valid", bus.root_valid, 0);
        check("rst_root_id",    bus.root_id,    0);
        rst_n = 1'b1;
        tick();

        // Main 16-leaf build, downstream always ready
        bus.m_ready = 1'b1;
        load(W_MAIN);
        collect(400);
        check_main_run("main");
        check("main_done_drop", bus.done, 0);
        check("main_busy_drop", bus.busy, 0);
        check("main_root_held", bus.root_id, 29);

        // All leaves absent
        for (int i = 0; i < 16; i++) w_vec[i] = 8'd0;
        load(w_vec);
        check("zero_rv_cleared", bus.root_valid, 0);
        collect(100);
        check("zero_nrec",   rec_n,    0);
        check("zero_root_v", res_rv,   0);
        check("zero_root",   res_root, 0);

        // Single leaf at index 7
        w_vec[7] = 8'd5;
        load(w_vec);
        collect(100);
        check("one_nrec",   rec_n,    0);
        check("one_root_v", res_rv,   1);
        check("one_root",   res_root, 7);

        // Parent weight saturation
        for (int i = 0; i < 16; i++) w_vec[i] = 8'd0;
        w_vec[0] = 8'd200;
        w_vec[1] = 8'd200;
        load(w_vec);
        collect(100);
        check("sat_nrec", rec_n,    1);
        check("sat_l",    rec_l[0], 0);
        check("sat_r",    rec_r[0], 1);
        check("sat_p",    rec_p[0], 16);
        check("sat_w",    rec_w[0], 254);
        check("sat_root", res_root, 16);

        // 255 must load as 254, tying with index 1 and losing on id
        w_vec[0] = 8'd255;
        w_vec[1] = 8'd254;
        load(w_vec);
        collect(100);
        check("clamp_nrec", rec_n,    1);
        check("clamp_l",    rec_l[0], 0);
        check("clamp_r",    rec_r[0], 1);
        check("clamp_w",    rec_w[0], 254);

        // Stall the first record; a start pulse mid-build is ignored
        bus.m_ready = 1'b0;
        load(W_MAIN);
        wait_mvalid(10);
        for (int k = 0; k < 5; k++) begin
            check("stall_valid", bus.m_valid, 1);
            check("stall_rec", {bus.m_left, bus.m_right, bus.m_parent, bus.m_weight},
                  {5'd11, 5'd5, 5'd16, 8'd3});
            bus.start = (k == 2);
            tick();
            bus.start = 1'b0;
        end
        bus.m_ready = 1'b1;
        tick();
        check("stall_accepted", bus.m_valid, 0);
        collect(400);
        check("stall_nrec",   rec_n,    13);
        check("stall_next_l", rec_l[0], 0);
        check("stall_next_p", rec_p[0], 17);
        check("stall_last_p", rec_p[12], 29);
        check("stall_root",   res_root, 29);

        // Reset while a record is pending
        bus.m_ready = 1'b0;
        load(W_MAIN);
        wait_mvalid(10);
        rst_n = 1'b0;
        #1;
        check("abort_m_valid",  bus.m_valid,  0);
        check("abort_busy",     bus.busy,     0);
        check("abort_done",     bus.done,     0);
        check("abort_in_ready", bus.in_ready, 0);
        repeat (2) tick();
        rst_n = 1'b1;
        tick();

        // A fresh build after the abort matches the first one
        bus.m_ready = 1'b1;
        load(W_MAIN);
        collect(400);
        check_main_run("rerun");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule : tb_huffman_merge_ctrl
`default_nettype wire

// File: doc/huffman_merge_ctrl.md
Name: huffman_merge_ctrl

Overview:
- Sequences the 16-entry combinational sorter to build a Huffman tree from 16 leaf weights.
- Loads the leaf weights serially, then repeats a sort/merge loop: takes the two smallest live nodes, emits one merge record per step, and writes the parent back into the node table.
- Sits between the frequency counter (upstream) and the code-length/tree RAM writer (downstream).

Parameters:
- WSIZE, 8, weight width in bits; the all-ones weight is reserved as the empty-slot sentinel.
- IDW, 5, node id width: leaves are 0..15, internal nodes are 16..30, and id 31 is the sentinel.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  begin a build; honoured only in IDLE
- in_valid  in  1  leaf weight valid
- in_ready  out  1  leaf weight accepted; high only in LOAD
- in_weight  in  WSIZE  leaf weight; leaf id is the arrival index 0..15; 0 means symbol absent
- m_valid  out  1  merge record valid
- m_ready  in  1  downstream accepts the merge record
- m_left  out  IDW  id of the smaller child
- m_right  out  IDW  id of the larger child
- m_parent  out  IDW  id of the new parent
- m_weight  out  WSIZE  parent weight
- busy  out  1  high in any state other than IDLE
- done  out  1  one-cycle pulse at the end of a build
- root_id  out  IDW  root node id; held until the next start
- root_valid  out  1  1 if the tree has at least one leaf; held until the next start

Behaviour:
- Reset: async to IDLE. All outputs are 0, the table is filled with sentinels, live=0, next_id=16.
- Table entry: key = {weight, id}, id in the low IDW bits. The sorter orders keys ascending, so equal weights tie-break on lower id (deterministic).
- Sentinel entry: key = {all-ones weight, id 31}; it always sorts last.
- IDLE: on start, clear the table to sentinels, set live=0 and next_id=16, clear root_valid, go to LOAD. start is ignored in every other state.
- LOAD:
  - in_ready=1. On each in_valid&&in_ready, write entry[idx]. Weight 0 writes a sentinel. A nonzero weight is clamped to 2^WSIZE-2, stored with id=idx, and increments live.
  - After the 16th accept, go to SORT.
- SORT (1 cycle): register sorter outputs s0..s15 into a snapshot; the sorter path stays combinational. If live<=1 go to DONE, else go to EMIT.
- EMIT:
  - Drive m_valid=1 with m_left=s0.id, m_right=s1.id, m_parent=next_id.
  - m_weight = s0.w + s1.w computed at WSIZE+1 bits, saturated to 2^WSIZE-2.
  - All m_* outputs stay stable while m_valid && !m_ready.
  - On handshake:
    - table <= {parent entry, s2..s15, sentinel}.
    - next_id += 1; live -= 1.
    - m_valid drops next cycle; go to SORT.
- DONE:
  - done=1 for one cycle.
  - root_valid = (live==1); root_id = s0.id if live==1, else 0.
  - Return to IDLE; busy drops the same edge.
- Latency: 16 load cycles (in_valid held), then 2 cycles per merge with m_ready=1, plus 1 SORT and 1 DONE cycle. At most 15 merges.
- Reset mid-operation: immediate abort. The partial record is discarded; downstream must treat rst_n as a flush.

Decomposition:
- Shared package:
  - N_LEAF=16.
  - Sentinel id constant 31 and FIRST_PARENT=16.
  - Entry typedef {weight, id}.
  - State enum IDLE, LOAD, SORT, EMIT, DONE.
- One sub-module: the existing SortX16 instance, DSIZE=WSIZE+IDW, OFFSET=IDW. No other sub-modules.

Test Plan:
- Load 3,9,15,6,12,2,8,14,4,10,0,1,7,23,13,5 with m_ready=1:
  - first record left=11, right=5, parent=16, weight=3;
  - second record left=0, right=16, parent=17, weight=6;
  - 14 records total; last record parent=29, weight=132;
  - done pulse with root_id=29, root_valid=1.
- All 16 weights 0 -> no m_valid; done pulse with root_valid=0, root_id=0. Only index 7 = 5 -> no records; root_id=7, root_valid=1.
- Same load as scenario 1 with m_ready held low 5 cycles on the first record -> m_* stable with values 11/5/16/3; record accepted on the first m_ready=1 cycle.
- WSIZE=8, weights 200 at index 0 and 200 at index 1, others 0 -> one record left=0, right=1, parent=16, weight=254 (saturated); input weight 255 loads as 254.
- rst_n low during EMIT -> next sample shows m_valid=0, busy=0, done=0, in_ready=0. start pulsed while busy is ignored; a new start after reset reproduces scenario 1 exactly.
